boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader_pkg.sv | 24 ++
 rtl/boot_loader.sv | 160 ++++++++++++++++
 tb/tb_boot_loader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/boot_loader_pkg.sv
// Shared widths and FSM state encoding for the serial program loader.
// BOOT_LOADER_CHECKSUM_EN adds the CHK state.
package boot_loader_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned INSTR_W = 19;
  localparam int unsigned LEN_W   = 16;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    B2,
    B1,
    B0,
    WRITE,
`ifdef BOOT_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/boot_loader.sv
// Byte-stream program loader: length header, 3-byte 19-bit words, IM write strobes.
// Optional trailing XOR checksum byte when BOOT_LOADER_CHECKSUM_EN is defined.
module boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned IM_AW = 19
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BYTE_W-1:0]  rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               im_we,
  output logic [IM_AW-1:0]   im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               cpu_rst_n,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [LEN_W-1:0]   word_cnt
);

  localparam logic [IM_AW-1:0] ADDR_MAX = IM_AW'(DEPTH - 1);
`ifdef BOOT_LOADER_CHECKSUM_EN
  localparam state_t S_FINAL = CHK;
`else
  localparam state_t S_FINAL = DONE;
`endif

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_len;
  logic [INSTR_W-1:0] r_wdata;
  logic [IM_AW-1:0]   r_addr;
  logic [LEN_W-1:0]   r_cnt;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [BYTE_W-1:0]  r_xor;
`endif

  logic             w_accept;
  logic             w_start;
  logic [LEN_W-1:0] w_len_in;
  logic [LEN_W-1:0] w_cnt_inc;
  logic             w_len_over;
  logic             w_last;

  assign w_accept   = rx_valid & rx_ready;
  assign w_start    = start & ((r_state == IDLE) | (r_state == DONE) | (r_state == ERR));
  assign w_len_in   = {r_len[LEN_W-1:BYTE_W], rx_data};
  assign w_cnt_inc  = r_cnt + LEN_W'(1);
  assign w_len_over = 32'(w_len_in) > DEPTH;
  assign w_last     = (w_cnt_inc == r_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: if (w_start) w_next = LEN_HI;
      LEN_HI:          if (w_accept) w_next = LEN_LO;
      LEN_LO: begin
        if (w_accept) begin
          if (w_len_over)          w_next = ERR;
          else if (w_len_in == '0) w_next = S_FINAL;
          else                     w_next = B2;
        end
      end
      B2:    if (w_accept) w_next = B1;
      B1:    if (w_accept) w_next = B0;
      B0:    if (w_accept) w_next = WRITE;
      WRITE: w_next = w_last ? S_FINAL : B2;
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHK:   if (w_accept) w_next = (rx_data == r_xor) ? DONE : ERR;
`endif
      default: w_next = IDLE;
    endcase
  end

  // Handshake and status decode from the registered state only, so rx_ready
  // never combinationally follows rx_valid.
  always_comb begin
    rx_ready  = 1'b0;
    im_we     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_rst_n = 1'b0;
    case (r_state)
      LEN_HI, LEN_LO, B2, B1, B0: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      CHK: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
`endif
      WRITE: begin
        im_we = 1'b1;
        busy  = 1'b1;
      end
      DONE: begin
        done      = 1'b1;
        cpu_rst_n = 1'b1;
      end
      ERR:     error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len   <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_xor   <= '0;
`endif
    end else begin
      if (w_start) begin
        r_addr <= '0;
        r_cnt  <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
        r_xor  <= '0;
`endif
      end
      if (w_accept) begin
        case (r_state)
          LEN_HI: r_len[LEN_W-1:BYTE_W] <= rx_data;
          LEN_LO: r_len[BYTE_W-1:0] <= rx_data;
          B2:     r_wdata[INSTR_W-1:2*BYTE_W] <= rx_data[INSTR_W-2*BYTE_W-1:0];
          B1:     r_wdata[2*BYTE_W-1:BYTE_W] <= rx_data;
          B0:     r_wdata[BYTE_W-1:0] <= rx_data;
          default: ;
        endcase
`ifdef BOOT_LOADER_CHECKSUM_EN
        if (r_state != CHK) r_xor <= r_xor ^ rx_data;
`endif
      end
      // Address saturates at the last word so a full-depth load never
      // presents an out-of-range address afterwards.
      if (r_state == WRITE) begin
        r_cnt <= w_cnt_inc;
        if (r_addr != ADDR_MAX) r_addr <= r_addr + IM_AW'(1);
      end
    end
  end

  assign im_addr  = r_addr;
  assign im_wdata = r_wdata;
  assign word_cnt = r_cnt;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader; reference model derives writes from the byte stream.
module tb_boot_loader;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned IM_AW = 19;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        im_we;
  logic [18:0] im_addr;
  logic [18:0] im_wdata;
  logic        cpu_rst_n;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] word_cnt;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;
  int unsigned addr_viol = 0;
  logic [37:0] wq[$];
  int unsigned wcyc[$];
  logic [7:0]  tx[$];

  boot_loader #(.DEPTH(DEPTH), .IM_AW(IM_AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (im_we === 1'b1) begin
      wq.push_back({im_addr, im_wdata});
      wcyc.push_back(cyc);
    end
    if (im_addr > 19'(DEPTH - 1)) addr_viol++;
  end

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "/rx_ready"}, rx_ready, 0);
    chk({tag, "/im_we"}, im_we, 0);
    chk({tag, "/im_addr"}, im_addr, 0);
    chk({tag, "/im_wdata"}, im_wdata, 0);
    chk({tag, "/word_cnt"}, word_cnt, 0);
    chk({tag, "/busy"}, busy, 0);
    chk({tag, "/done"}, done, 0);
    chk({tag, "/error"}, error, 0);
    chk({tag, "/cpu_rst_n"}, cpu_rst_n, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stall);
    int unsigned guard = 0;
    bit sent = 1'b0;
    while (!sent && guard < 200) begin
      @(negedge clk);
      rx_data  = b;
      rx_valid = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rx_valid && rx_ready) sent = 1'b1;
      guard++;
    end
    if (!sent) chk("rx_accept_timeout", 0, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fill_random(input int unsigned n);
    tx.delete();
    tx.push_back(8'(n >> 8));
    tx.push_back(8'(n));
    for (int unsigned i = 0; i < 3 * n; i++) tx.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: length is big-endian in tx[0..1]; word i is {tx[2+3i][2:0], tx[3+3i], tx[4+3i]}
  // written at address i; over-length loads write nothing and fail.
  task automatic run_load(input string tag, input bit stall, input int inject_at, input bit corrupt);
    int unsigned n, exp_n, nsend, guard;
    bit          over, ok;
    logic [7:0]  cs;
    logic [18:0] w;
    logic [37:0] expw;
    wq.delete();
    wcyc.delete();
    n     = {16'd0, tx[0], tx[1]};
    over  = n > DEPTH;
    exp_n = over ? 0 : n;
    nsend = over ? 2 : tx.size();
    ok    = !over && !corrupt;
    cs    = '0;
    for (int unsigned i = 0; i < nsend; i++) cs ^= tx[i];

    pulse_start();
    chk({tag, "/start_busy"}, busy, 1);
    chk({tag, "/start_cpu_rst_n"}, cpu_rst_n, 0);
    chk({tag, "/start_word_cnt"}, word_cnt, 0);
    chk({tag, "/start_im_addr"}, im_addr, 0);

    for (int unsigned i = 0; i < nsend; i++) begin
      send_byte(tx[i], stall);
      if (int'(i) == inject_at) begin
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        chk({tag, "/inject_busy"}, busy, 1);
      end
    end
`ifdef BOOT_LOADER_CHECKSUM_EN
    if (!over) send_byte(corrupt ? ~cs : cs, stall);
`endif
    @(negedge clk);
    rx_valid = 1'b0;
    guard = 0;
    while (!(done || error) && guard < 40) begin
      @(negedge clk);
      guard++;
    end

    chk({tag, "/done"}, done, ok);
    chk({tag, "/error"}, error, !ok);
    chk({tag, "/cpu_rst_n"}, cpu_rst_n, ok);
    chk({tag, "/busy"}, busy, 0);
    chk({tag, "/word_cnt"}, word_cnt, exp_n);
    chk({tag, "/n_writes"}, wq.size(), exp_n);
    for (int unsigned i = 0; i < exp_n && i < wq.size(); i++) begin
      w    = {tx[2 + 3 * i][2:0], tx[3 + 3 * i], tx[4 + 3 * i]};
      expw = {19'(i), w};
      chk({tag, "/write"}, wq[i], expw);
    end
  endtask

  initial begin
    // Power-on reset
    #3 rst = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_rx_ready", rx_ready, 0);

    // Directed two-word load with continuous valid
    tx = '{8'h00, 8'h02, 8'h05, 8'h12, 8'h34, 8'h02, 8'hAB, 8'hCD};
    run_load("directed", 1'b0, -1, 1'b0);
    if (wq.size() >= 2) begin
      chk("directed/w0_const", wq[0], {19'd0, 19'h51234});
      chk("directed/w1_const", wq[1], {19'd1, 19'h2ABCD});
      chk("directed/throughput", wcyc[1] - wcyc[0], 4);
    end

    // New load from DONE, with a start pulse ignored while in B1
    fill_random(2);
    run_load("start_in_b1", 1'b0, 2, 1'b0);

    // Over-length header
    tx = '{8'h04, 8'h01};
    run_load("over_len", 1'b0, -1, 1'b0);

    // Zero-length load
    tx = '{8'h00, 8'h00};
    run_load("zero_len", 1'b0, -1, 1'b0);

    // Same three-word stream without and with random stalls
    fill_random(3);
    run_load("nostall3", 1'b0, -1, 1'b0);
    run_load("stall3", 1'b1, -1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      fill_random($urandom_range(1, 6));
      run_load("rand", 1'b1, -1, 1'b0);
    end

    // Full-depth load: address must stop at DEPTH-1
    fill_random(DEPTH);
    run_load("full_depth", 1'b0, -1, 1'b0);
    chk("full_depth/im_addr", im_addr, DEPTH - 1);

`ifdef BOOT_LOADER_CHECKSUM_EN
    tx = '{8'h00, 8'h01, 8'h07, 8'hFF, 8'hFF};
    run_load("cksum_good", 1'b0, -1, 1'b0);
    run_load("cksum_bad", 1'b0, -1, 1'b1);
`endif

    // Asynchronous reset after the second write of a three-word load
    fill_random(3);
    wq.delete();
    pulse_start();
    for (int unsigned i = 0; i < 8; i++) send_byte(tx[i], 1'b0);
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      #1;
      if (wq.size() >= 2) break;
    end
    chk("midrst/writes_before", wq.size(), 2);
    #1 rst = 1'b0;
    #1 chk_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    chk("midrst/no_more_writes", wq.size(), 2);
    rst = 1'b1;
    fill_random(1);
    run_load("after_rst", 1'b0, -1, 1'b0);

    chk("addr_in_range", addr_viol, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
